// File: rtl/image_batch_sequencer.sv
// image_batch_sequencer
// Steps a classifier network through a batch of NUM_IMAGES images. For each
// image the sequencer sends a one-cycle start pulse, waits for the network's
// result, and republishes it as label/label_num/label_ready. Each result is
// compared with the golden label, and correct_count holds the number of matches
// in the current batch.
//
// Optional feature: define IMAGE_BATCH_TIMEOUT_EN to enable a per-image
// watchdog. An image that gets no answer within TIMEOUT_CYCLES cycles of WAIT is
// recorded as label 0 / no match, and the sticky timeout flag is set. Without
// the macro there is no watchdog, WAIT waits indefinitely, and timeout is 0.
module image_batch_sequencer #(
  parameter int NUM_IMAGES     = 4,
  parameter int NUM_CLASSES    = 10,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int NW = $clog2(NUM_IMAGES + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  output logic          net_start,
  output logic [IW-1:0] net_image_num,
  input  logic [CW-1:0] net_label,
  input  logic          net_label_ready,
  input  logic [CW-1:0] expected_label,
  output logic [CW-1:0] label,
  output logic [IW-1:0] label_num,
  output logic          label_ready,
  output logic [NW-1:0] correct_count,
  output logic          busy,
  output logic          done,
  output logic          timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RECORD,
    S_DONE
  } state_t;

  localparam logic [IW-1:0] LAST_IMAGE = IW'(NUM_IMAGES - 1);
  localparam logic [NW-1:0] MAX_COUNT  = NW'(NUM_IMAGES);

  state_t state;
  logic   match;

`ifdef IMAGE_BATCH_TIMEOUT_EN
  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt;
  logic          timeout_q;

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Sequencer FSM; every output is a register and is updated on the transition into the state it belongs to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      net_start     <= 1'b0;
      net_image_num <= '0;
      label         <= '0;
      label_num     <= '0;
      label_ready   <= 1'b0;
      correct_count <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      match         <= 1'b0;
`ifdef IMAGE_BATCH_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments are used throughout, so every branch reads the pre-edge state and the later defaults-then-overrides ordering is safe.
      net_start   <= 1'b0;
      label_ready <= 1'b0;

      case (state)
        S_IDLE: begin
          if (enable) begin
            state         <= S_START;
            net_start     <= 1'b1;
            busy          <= 1'b1;
            net_image_num <= '0;
            correct_count <= '0;
`ifdef IMAGE_BATCH_TIMEOUT_EN
            timeout_q     <= 1'b0;
`endif
          end
        end

        S_START: begin
          state <= S_WAIT;
`ifdef IMAGE_BATCH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        S_WAIT: begin
          if (net_label_ready) begin
            state       <= S_RECORD;
            label       <= net_label;
            label_num   <= net_image_num;
            match       <= (net_label == expected_label);
            label_ready <= 1'b1;
          end
`ifdef IMAGE_BATCH_TIMEOUT_EN
          else if (wait_cnt == LAST_WAIT) begin
            // Record an unanswered image as a failed classification.
            state       <= S_RECORD;
            label       <= '0;
            label_num   <= net_image_num;
            match       <= 1'b0;
            label_ready <= 1'b1;
            timeout_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
`endif
        end

        S_RECORD: begin
          if (match && (correct_count < MAX_COUNT)) begin
            correct_count <= correct_count + NW'(1);
          end
          if (net_image_num == LAST_IMAGE) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state         <= S_START;
            net_start     <= 1'b1;
            net_image_num <= net_image_num + IW'(1);
          end
        end

        S_DONE: begin
          // Results stay frozen until the requester drops enable.
          if (!enable) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_batch_sequencer.sv
// Self-checking bench for image_batch_sequencer (NUM_IMAGES=4, NUM_CLASSES=10,
// TIMEOUT_CYCLES=16). It applies a table of batch vectors, runs randomized
// batches against a count-of-matches reference model, and uses hand-written
// sequences for reset, enable drop, ignored responses and (with the macro) the
// watchdog.
module tb_image_batch_sequencer;

  localparam int N_IMG = 4;
  localparam int N_CLS = 10;
  localparam int IW    = 2;
  localparam int CW    = 4;
  localparam int NW    = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          net_start;
  logic [IW-1:0] net_image_num;
  logic [CW-1:0] net_label = '0;
  logic          net_label_ready = 1'b0;
  logic [CW-1:0] expected_label = '0;
  logic [CW-1:0] label;
  logic [IW-1:0] label_num;
  logic          label_ready;
  logic [NW-1:0] correct_count;
  logic          busy;
  logic          done;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  image_batch_sequencer #(
    .NUM_IMAGES    (N_IMG),
    .NUM_CLASSES   (N_CLS),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .net_start      (net_start),
    .net_image_num  (net_image_num),
    .net_label      (net_label),
    .net_label_ready(net_label_ready),
    .expected_label (expected_label),
    .label          (label),
    .label_num      (label_num),
    .label_ready    (label_ready),
    .correct_count  (correct_count),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [CW-1:0] ans [N_IMG];
    logic [CW-1:0] gold[N_IMG];
    int            dly [N_IMG];
    int            exp_count;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic answer(input logic [CW-1:0] l);
    net_label       = l;
    net_label_ready = 1'b1;
    tick();
    net_label_ready = 1'b0;
    net_label       = CW'($urandom_range(0, N_CLS - 1));
  endtask

  // Reference model: the score of a batch is the number of answers equal to the golden labels.
  function automatic int model_count(input logic [CW-1:0] ans[N_IMG], input logic [CW-1:0] gold[N_IMG]);
    int n = 0;
    for (int i = 0; i < N_IMG; i++) if (ans[i] == gold[i]) n++;
    return n;
  endfunction

  // Drive one full batch from IDLE and check every per-image event and the final score.
  task automatic run_batch(input logic [CW-1:0] ans[N_IMG], input logic [CW-1:0] gold[N_IMG],
                           input int dly[N_IMG], input bit drop_enable, input int exp_count);
    enable = 1'b1;
    tick();
    check("start_latency", net_start, 1);
    check("count_cleared", correct_count, 0);
    check("busy_in_start", busy, 1);
    for (int i = 0; i < N_IMG; i++) begin
      int n = 0;
      while (!net_start && n < 20) begin
        tick();
        n++;
      end
      check("start_seen", net_start, 1);
      check("image_num", net_image_num, i);
      if (drop_enable) enable = 1'b0;
      expected_label = gold[i];
      tick();
      check("start_one_cycle", net_start, 0);
      check("no_early_ready", label_ready, 0);
      for (int d = 0; d < dly[i]; d++) tick();
      answer(ans[i]);
      check("label_ready", label_ready, 1);
      check("label", label, ans[i]);
      check("label_num", label_num, i);
      tick();
      check("label_ready_one_cycle", label_ready, 0);
      if (i < N_IMG - 1) check("next_start_latency", net_start, 1);
      else               check("done_after_last", done, 1);
    end
    check("correct_count", correct_count, exp_count);
    check("busy_in_done", busy, 0);
    check("timeout_clear", timeout, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0].ans = '{4'd7, 4'd3, 4'd3, 4'd1}; vecs[0].gold = '{4'd7, 4'd3, 4'd5, 4'd1};
    vecs[0].dly = '{0, 2, 1, 0};             vecs[0].exp_count = 3;
    vecs[1].ans = '{4'd0, 4'd9, 4'd4, 4'd2}; vecs[1].gold = '{4'd0, 4'd9, 4'd4, 4'd2};
    vecs[1].dly = '{3, 0, 0, 1};             vecs[1].exp_count = 4;
    vecs[2].ans = '{4'd1, 4'd1, 4'd1, 4'd1}; vecs[2].gold = '{4'd2, 4'd3, 4'd4, 4'd5};
    vecs[2].dly = '{1, 1, 1, 1};             vecs[2].exp_count = 0;
    vecs[3].ans = '{4'd8, 4'd6, 4'd5, 4'd9}; vecs[3].gold = '{4'd8, 4'd0, 4'd5, 4'd0};
    vecs[3].dly = '{0, 0, 4, 0};             vecs[3].exp_count = 2;

    // Reset state.
    tick();
    tick();
    check("rst_net_start", net_start, 0);
    check("rst_label_ready", label_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_label", label, 0);
    check("rst_label_num", label_num, 0);
    check("rst_image_num", net_image_num, 0);
    check("rst_count", correct_count, 0);
    reset = 1'b1;
    tick();
    check("idle_no_start", net_start, 0);

    // A response while IDLE is ignored.
    answer(4'd5);
    check("idle_ready_ignored", label_ready, 0);
    check("idle_label_kept", label, 0);
    check("idle_busy", busy, 0);

    // Table-driven batches, each followed by DONE hold behaviour.
    for (int v = 0; v < 4; v++) begin
      run_batch(vecs[v].ans, vecs[v].gold, vecs[v].dly, 1'b0, vecs[v].exp_count);
      tick();
      check("done_held", done, 1);
      check("done_label_frozen", label, vecs[v].ans[N_IMG-1]);
      answer(4'd9);
      check("done_ready_ignored", label_ready, 0);
      check("done_count_kept", correct_count, vecs[v].exp_count);
      check("done_label_kept", label, vecs[v].ans[N_IMG-1]);
      enable = 1'b0;
      tick();
      check("idle_after_done", done, 0);
      check("idle_count_held", correct_count, vecs[v].exp_count);
    end

    // Enable dropped after the first start pulse: the batch still completes.
    run_batch(vecs[0].ans, vecs[0].gold, vecs[0].dly, 1'b1, 3);
    tick();
    check("drop_back_to_idle", done, 0);
    check("drop_no_restart", net_start, 0);
    check("drop_not_busy", busy, 0);

    // Reset during WAIT of image 2 discards the batch.
    enable = 1'b1;
    expected_label = 4'd1;
    tick();
    tick();
    answer(4'd1);
    tick();
    tick();
    answer(4'd1);
    tick();
    check("mid_image_2", net_image_num, 2);
    tick();
    check("mid_in_wait", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_image_num", net_image_num, 0);
    check("async_count", correct_count, 0);
    check("async_label", label, 0);
    check("async_label_num", label_num, 0);
    check("async_net_start", net_start, 0);
    enable = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("post_reset_idle", busy, 0);
    run_batch(vecs[3].ans, vecs[3].gold, vecs[3].dly, 1'b0, 2);
    enable = 1'b0;
    tick();

    // Randomized batches against the reference model.
    for (int b = 0; b < 25; b++) begin
      vec_t r;
      for (int i = 0; i < N_IMG; i++) begin
        r.ans[i]  = CW'($urandom_range(0, N_CLS - 1));
        r.gold[i] = ($urandom_range(0, 1) == 1) ? r.ans[i] : CW'($urandom_range(0, N_CLS - 1));
        r.dly[i]  = $urandom_range(0, 4);
      end
      r.exp_count = model_count(r.ans, r.gold);
      run_batch(r.ans, r.gold, r.dly, bit'($urandom_range(0, 1)), r.exp_count);
      enable = 1'b0;
      tick();
      check("rand_back_to_idle", done, 0);
    end

`ifdef IMAGE_BATCH_TIMEOUT_EN
    // Watchdog: image 1 is never answered.
    begin
      int n = 0;
      enable = 1'b1;
      expected_label = 4'd2;
      tick();
      tick();
      answer(4'd2);
      tick();
      tick();
      while (!label_ready && n < 40) begin
        tick();
        n++;
      end
      check("to_ready", label_ready, 1);
      check("to_label", label, 0);
      check("to_label_num", label_num, 1);
      check("to_flag", timeout, 1);
      for (int i = 2; i < N_IMG; i++) begin
        tick();
        tick();
        answer(4'd2);
      end
      tick();
      check("to_done", done, 1);
      check("to_count", correct_count, 3);
      check("to_sticky", timeout, 1);
      enable = 1'b0;
      tick();
      enable = 1'b1;
      tick();
      check("to_cleared", timeout, 0);
      reset = 1'b0;
      enable = 1'b0;
      tick();
      reset = 1'b1;
      tick();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
